// File: rtl/issue_pkg.sv
// Shared definitions for the RV32I issue stage: opcode constants, the
// operand-usage record and the decoder that fills it from an instruction word.
package issue_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic rd_we;
  } operand_use_t;

  // Which register fields an instruction reads/writes. rd == x0 never writes.
  function automatic operand_use_t decode_operands(input logic [31:0] instr);
    operand_use_t u;
    u = '0;
    case (instr[6:0])
      OPC_R: begin
        u.use_rs1 = 1'b1;
        u.use_rs2 = 1'b1;
        u.rd_we   = 1'b1;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        u.use_rs1 = 1'b1;
        u.rd_we   = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        u.use_rs1 = 1'b1;
        u.use_rs2 = 1'b1;
      end
      OPC_JAL, OPC_LUI, OPC_AUIPC: begin
        u.rd_we = 1'b1;
      end
      default: ;
    endcase
    if (instr[11:7] == 5'd0) u.rd_we = 1'b0;
    return u;
  endfunction

endpackage

// File: rtl/issue_if.sv
// Instruction handshake bundle around the issue stage: fetch -> issue
// (i_valid/i_instr/i_pc, o_ready) and issue -> EX (o_valid/o_instr/o_pc/
// o_rd/o_rd_we, i_ready). Names are seen from the issue stage.
// Modports: slave = issue stage, master = surrounding pipeline / bench.
interface issue_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            i_valid;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc;
  logic            o_ready;
  logic            o_valid;
  logic            i_ready;
  logic [31:0]     o_instr;
  logic [XLEN-1:0] o_pc;
  logic [AW-1:0]   o_rd;
  logic            o_rd_we;

  modport slave (
    input  i_valid, i_instr, i_pc, i_ready,
    output o_ready, o_valid, o_instr, o_pc, o_rd, o_rd_we
  );

  modport master (
    output i_valid, i_instr, i_pc, i_ready,
    input  o_ready, o_valid, o_instr, o_pc, o_rd, o_rd_we
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard.
// Ports: i_clk/i_rst_n (async active-low), set (issue), clr (writeback),
// flush clear (killed instruction), three effective-pending lookups where a
// same-cycle writeback is already treated as complete.
module reg_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_set_en,
  input  logic [AW-1:0]   i_set_idx,
  input  logic            i_clr_en,
  input  logic [AW-1:0]   i_clr_idx,
  input  logic            i_fclr_en,
  input  logic [AW-1:0]   i_fclr_idx,
  input  logic [AW-1:0]   i_idx_a,
  input  logic [AW-1:0]   i_idx_b,
  input  logic [AW-1:0]   i_idx_c,
  output logic            o_eff_a,
  output logic            o_eff_b,
  output logic            o_eff_c
);

  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] eff;

  always_comb begin
    eff = pending_q;
    if (i_clr_en) eff[i_clr_idx] = 1'b0;
  end

  assign o_eff_a = eff[i_idx_a];
  assign o_eff_b = eff[i_idx_b];
  assign o_eff_c = eff[i_idx_c];

  // Set is applied last so it wins over a same-register clear.
  always_comb begin
    pending_d = pending_q;
    if (i_fclr_en) pending_d[i_fclr_idx] = 1'b0;
    if (i_clr_en)  pending_d[i_clr_idx]  = 1'b0;
    if (i_set_en)  pending_d[i_set_idx]  = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

endmodule

// File: rtl/issue_stage.sv
// RV32I decode/issue stage in front of the register file.
// Ports: i_clk, i_rst_n (async active-low); bus (issue_if.slave) carries the
// fetch-side and EX-side handshakes; o_a1/o_a2 register-file read addresses;
// i_flush kills the held instruction; i_wb_we/i_wb_rd mirror the register-file
// write port and retire scoreboard entries.
// Optional: ISSUE_STALL_CNT_EN adds o_stall_cnt, a wrapping count of hazard
// stall cycles.
module issue_stage
  import issue_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  issue_if.slave        bus,
  output logic [AW-1:0] o_a1,
  output logic [AW-1:0] o_a2,
  input  logic          i_flush,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_rd
`ifdef ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]   o_stall_cnt
`endif
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  operand_use_t    in_use, held_use;
  logic [AW-1:0]   rs1, rs2, rd, held_rs1, held_rs2, held_rd;
  logic            eff1, eff2, eff3;
  logic            hazard, accept, flush_clr;

  assign in_use   = decode_operands(bus.i_instr);
  assign rs1      = bus.i_instr[15 +: AW];
  assign rs2      = bus.i_instr[20 +: AW];
  assign rd       = bus.i_instr[7 +: AW];

  // rd/rd_we of the held instruction are re-derived from the held word;
  // the all-zero reset word decodes to rd=0, rd_we=0.
  assign held_use = decode_operands(instr_q);
  assign held_rs1 = instr_q[15 +: AW];
  assign held_rs2 = instr_q[20 +: AW];
  assign held_rd  = instr_q[7 +: AW];

  assign hazard = bus.i_valid & ((in_use.use_rs1 & eff1) | (in_use.use_rs2 & eff2) |
                                 (in_use.rd_we & eff3));
  assign bus.o_ready = (~valid_q | bus.i_ready) & ~hazard & ~i_flush;
  assign accept      = bus.i_valid & bus.o_ready;

  // Only a live held instruction owns its pending bit; once it left for EX
  // the write will retire normally.
  assign flush_clr = i_flush & valid_q & held_use.rd_we;

  always_comb begin
    if (accept) begin
      o_a1 = rs1;
      o_a2 = rs2;
    end else begin
      o_a1 = held_use.use_rs1 ? held_rs1 : '0;
      o_a2 = held_use.use_rs2 ? held_rs2 : '0;
    end
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (accept) begin
      valid_d = 1'b1;
      instr_d = bus.i_instr;
      pc_d    = bus.i_pc;
    end else if (i_flush || bus.i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_instr = instr_q;
  assign bus.o_pc    = pc_q;
  assign bus.o_rd    = held_rd;
  assign bus.o_rd_we = held_use.rd_we;

  reg_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_set_en   (accept & in_use.rd_we),
    .i_set_idx  (rd),
    .i_clr_en   (i_wb_we),
    .i_clr_idx  (i_wb_rd),
    .i_fclr_en  (flush_clr),
    .i_fclr_idx (held_rd),
    .i_idx_a    (rs1),
    .i_idx_b    (rs2),
    .i_idx_c    (rd),
    .o_eff_a    (eff1),
    .o_eff_b    (eff2),
    .o_eff_c    (eff3)
  );

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    stall_cnt_q <= '0;
    else if (hazard) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Directed self-checking bench for issue_stage.
module tb_issue_stage;

  logic       i_clk;
  logic       i_rst_n;
  logic [4:0] o_a1, o_a2;
  logic       i_flush;
  logic       i_wb_we;
  logic [4:0] i_wb_rd;
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Hand-encoded instructions
  localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] ADDI_X2_7  = 32'h0070_0113;  // addi x2,x0,7
  localparam logic [31:0] ADD_X3_11  = 32'h0010_81B3;  // add x3,x1,x1
  localparam logic [31:0] ADD_X3_12  = 32'h0020_81B3;  // add x3,x1,x2
  localparam logic [31:0] LW_X5      = 32'h0000_2283;  // lw x5,0(x0)
  localparam logic [31:0] ADDI_X5_1  = 32'h0010_0293;  // addi x5,x0,1
  localparam logic [31:0] ADDI_X6_1  = 32'h0010_0313;  // addi x6,x0,1
  localparam logic [31:0] ADDI_X4_1  = 32'h0010_0213;  // addi x4,x0,1
  localparam logic [31:0] ADDI_X7_1  = 32'h0010_0393;  // addi x7,x0,1
  localparam logic [31:0] ADDI_X0_1  = 32'h0010_0013;  // addi x0,x0,1

  issue_if #(.XLEN(32), .AW(5)) bus ();

  issue_stage #(.XLEN(32), .NREG(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus),
    .o_a1    (o_a1),
    .o_a2    (o_a2),
    .i_flush (i_flush),
    .i_wb_we (i_wb_we),
    .i_wb_rd (i_wb_rd)
`ifdef ISSUE_STALL_CNT_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Combinational outputs sampled mid-cycle.
  task automatic at_neg();
    @(negedge i_clk);
  endtask

  task automatic present(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.i_valid = v;
    bus.i_instr = instr;
    bus.i_pc    = pc;
  endtask

  function automatic logic [31:0] pend();
    return dut.u_scoreboard.pending_q;
  endfunction

  initial begin
    i_rst_n     = 1'b0;
    i_flush     = 1'b0;
    i_wb_we     = 1'b0;
    i_wb_rd     = 5'd0;
    bus.i_ready = 1'b1;
    present(1'b0, 32'h0, 32'h0);
    #12;
    check("rst_valid", bus.o_valid, 0);
    check("rst_instr", bus.o_instr, 0);
    check("rst_pc", bus.o_pc, 0);
    check("rst_rd_we", bus.o_rd_we, 0);
    check("rst_pending", pend(), 0);
`ifdef ISSUE_STALL_CNT_EN
    check("rst_stall_cnt", o_stall_cnt, 0);
`endif
    at_neg();
    i_rst_n = 1'b1;
    step();

    // Back-to-back independent instructions
    present(1'b1, ADDI_X1_5, 32'h100);
    at_neg();
    check("b2b_ready0", bus.o_ready, 1);
    step();
    check("b2b_valid0", bus.o_valid, 1);
    check("b2b_instr0", bus.o_instr, ADDI_X1_5);
    check("b2b_rd0", bus.o_rd, 1);
    present(1'b1, ADDI_X2_7, 32'h104);
    at_neg();
    check("b2b_ready1", bus.o_ready, 1);
    step();
    check("b2b_valid1", bus.o_valid, 1);
    check("b2b_pc1", bus.o_pc, 32'h104);
    check("b2b_pending", pend(), 32'h0000_0006);
    present(1'b0, 32'h0, 32'h0);
    step();
    check("b2b_drain", bus.o_valid, 0);
    i_wb_we = 1'b1; i_wb_rd = 5'd1;
    step();
    i_wb_rd = 5'd2;
    step();
    i_wb_we = 1'b0;
    check("b2b_retired", pend(), 0);

    // RAW hazard resolved by same-cycle writeback
    present(1'b1, ADDI_X1_5, 32'h200);
    step();
    present(1'b1, ADD_X3_11, 32'h204);
    at_neg();
    check("raw_stall_ready", bus.o_ready, 0);
    step();
    check("raw_stall_valid", bus.o_valid, 0);
    check("raw_stall_pend", pend(), 32'h0000_0002);
    i_wb_we = 1'b1; i_wb_rd = 5'd1;
    at_neg();
    check("raw_bypass_ready", bus.o_ready, 1);
    check("raw_a1", o_a1, 1);
    check("raw_a2", o_a2, 1);
    step();
    i_wb_we = 1'b0;
    check("raw_issue_valid", bus.o_valid, 1);
    check("raw_issue_instr", bus.o_instr, ADD_X3_11);
    check("raw_pending", pend(), 32'h0000_0008);
    present(1'b0, 32'h0, 32'h0);
    i_wb_we = 1'b1; i_wb_rd = 5'd3;
    step();
    i_wb_we = 1'b0;
    check("raw_retired", pend(), 0);

    // WAW hazard; set wins over same-register clear
    present(1'b1, LW_X5, 32'h300);
    step();
    check("waw_lw_pend", pend(), 32'h0000_0020);
    present(1'b1, ADDI_X5_1, 32'h304);
    at_neg();
    check("waw_stall_ready", bus.o_ready, 0);
    step();
    step();
    check("waw_stall_valid", bus.o_valid, 0);
    i_wb_we = 1'b1; i_wb_rd = 5'd5;
    at_neg();
    check("waw_wb_ready", bus.o_ready, 1);
    step();
    check("waw_issue_instr", bus.o_instr, ADDI_X5_1);
    check("waw_set_wins", pend(), 32'h0000_0020);
    present(1'b0, 32'h0, 32'h0);
    step();
    i_wb_we = 1'b0;
    check("waw_retired", pend(), 0);

    // Backpressure: held add x3,x1,x2 stays stable
    bus.i_ready = 1'b0;
    present(1'b1, ADD_X3_12, 32'h400);
    step();
    present(1'b1, ADDI_X6_1, 32'h404);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("bp_ready", bus.o_ready, 0);
      check("bp_a1", o_a1, 1);
      check("bp_a2", o_a2, 2);
      step();
      check("bp_valid", bus.o_valid, 1);
      check("bp_instr", bus.o_instr, ADD_X3_12);
      check("bp_pc", bus.o_pc, 32'h400);
    end
    bus.i_ready = 1'b1;
    at_neg();
    check("bp_release_ready", bus.o_ready, 1);
    step();
    check("bp_next_instr", bus.o_instr, ADDI_X6_1);
    check("bp_pending", pend(), 32'h0000_0048);
    present(1'b0, 32'h0, 32'h0);
    i_wb_we = 1'b1; i_wb_rd = 5'd3;
    step();
    i_wb_rd = 5'd6;
    step();
    i_wb_we = 1'b0;
    check("bp_retired", pend(), 0);

    // Flush of a held instruction releases its pending bit
    bus.i_ready = 1'b0;
    present(1'b1, ADDI_X4_1, 32'h500);
    step();
    check("fl_pend_set", pend(), 32'h0000_0010);
    check("fl_rd_we", bus.o_rd_we, 1);
    present(1'b1, ADDI_X7_1, 32'h504);
    i_flush = 1'b1;
    bus.i_ready = 1'b1;
    at_neg();
    check("fl_ready", bus.o_ready, 0);
    step();
    i_flush = 1'b0;
    present(1'b0, 32'h0, 32'h0);
    check("fl_valid", bus.o_valid, 0);
    check("fl_pend_clr", pend(), 0);
    check("fl_no_accept", bus.o_instr, ADDI_X4_1);

    // rd = x0 never becomes pending
    present(1'b1, ADDI_X0_1, 32'h600);
    step();
    check("x0_valid", bus.o_valid, 1);
    check("x0_rd_we", bus.o_rd_we, 0);
    check("x0_pend", pend(), 0);

    // Asynchronous reset in the middle of a stall
    present(1'b1, LW_X5, 32'h700);
    step();
    bus.i_ready = 1'b0;
    present(1'b1, ADDI_X5_1, 32'h704);
    at_neg();
    check("rs_stall_ready", bus.o_ready, 0);
    step();
    check("rs_pre_valid", bus.o_valid, 1);
    check("rs_pre_pend", pend(), 32'h0000_0020);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("rs_valid", bus.o_valid, 0);
    check("rs_pend", pend(), 0);
    check("rs_instr", bus.o_instr, 0);
    check("rs_rd_we", bus.o_rd_we, 0);
`ifdef ISSUE_STALL_CNT_EN
    check("rs_stall_cnt", o_stall_cnt, 0);
`endif
    present(1'b0, 32'h0, 32'h0);
    at_neg();
    i_rst_n = 1'b1;
    step();
    check("post_rst_valid", bus.o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
